// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: FSM encoding and
// default datapath widths / access timeout.
package mem_access_stage_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int REG_W_DEF   = 4;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } state_t;

endpackage

// File: rtl/mem_access_stage_timeout.sv
// Access timeout counter: counts cycles spent waiting for memAck and flags the
// last permitted cycle so the stage can abandon the request.
module mem_timeout_ctr
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage between EX/MEM and MEMWBBuffer: passes ALU ops through in
// one cycle, runs loads/stores against data memory, honours the hazard freeze.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hazard,
    input  logic              validIn,
    input  logic [DATA_W-1:0] aluIn,
    input  logic [DATA_W-1:0] storeData,
    input  logic [REG_W-1:0]  destReg,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              regWrite,
    output logic              stallOut,
    output logic              memReq,
    output logic              memWe,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRData,
    output logic [DATA_W-1:0] aluOut,
    output logic [DATA_W-1:0] dataOut,
    output logic [REG_W-1:0]  R0Out,
    output logic              regWriteOut,
    output logic              validOut,
    output logic              memErr,
    output logic [1:0]        state_dbg
);

    // Memory handshake: memReq rises with memAddr/memWe/memWData stable and
    // stays high until the cycle memAck=1 (one-cycle pulse) is sampled, or the
    // timeout fires; memAck seen while memReq=0 is ignored.

    state_t state, state_d;

    logic              memreq_d, memwe_d;
    logic [DATA_W-1:0] memaddr_d, memwdata_d;
    logic [REG_W-1:0]  lat_dest, lat_dest_d;
    logic              lat_rw, lat_rw_d;
    logic              lat_read, lat_read_d;
    logic [DATA_W-1:0] rdata_cap, rdata_cap_d;
    logic [DATA_W-1:0] aluout_d, dataout_d;
    logic [REG_W-1:0]  r0out_d;
    logic              rwout_d, validout_d, memerr_d;
    logic              retire;
    logic [DATA_W-1:0] retire_rdata;
    logic              expired;

    mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != ACCESS),
        .enable  (state == ACCESS),
        .expired (expired)
    );

    assign stallOut  = hazard | (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d      = state;
        memreq_d     = memReq;
        memwe_d      = memWe;
        memaddr_d    = memAddr;
        memwdata_d   = memWData;
        lat_dest_d   = lat_dest;
        lat_rw_d     = lat_rw;
        lat_read_d   = lat_read;
        rdata_cap_d  = rdata_cap;
        aluout_d     = aluOut;
        dataout_d    = dataOut;
        r0out_d      = R0Out;
        rwout_d      = regWriteOut;
        validout_d   = hazard ? validOut : 1'b0;
        memerr_d     = 1'b0;
        retire       = 1'b0;
        retire_rdata = memRData;

        unique case (state)
            IDLE: begin
                if (validIn && !hazard) begin
                    if (memRead && memWrite) begin
                        memerr_d = 1'b1;
                    end else if (memRead || memWrite) begin
                        state_d    = ACCESS;
                        memreq_d   = 1'b1;
                        memwe_d    = memWrite;
                        memaddr_d  = aluIn;
                        memwdata_d = storeData;
                        lat_dest_d = destReg;
                        lat_rw_d   = regWrite;
                        lat_read_d = memRead;
                    end else begin
                        aluout_d   = aluIn;
                        dataout_d  = '0;
                        r0out_d    = destReg;
                        rwout_d    = regWrite;
                        validout_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // An ack in the final timeout cycle still completes the access.
                if (memAck) begin
                    memreq_d = 1'b0;
                    if (hazard) begin
                        rdata_cap_d = memRData;
                        state_d     = HOLD;
                    end else begin
                        retire  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (expired) begin
                    memreq_d = 1'b0;
                    memerr_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            HOLD: begin
                if (!hazard) begin
                    retire       = 1'b1;
                    retire_rdata = rdata_cap;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (retire) begin
            aluout_d   = memAddr;
            dataout_d  = lat_read ? retire_rdata : '0;
            r0out_d    = lat_dest;
            rwout_d    = lat_rw;
            validout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            memReq      <= 1'b0;
            memWe       <= 1'b0;
            memAddr     <= '0;
            memWData    <= '0;
            lat_dest    <= '0;
            lat_rw      <= 1'b0;
            lat_read    <= 1'b0;
            rdata_cap   <= '0;
            aluOut      <= '0;
            dataOut     <= '0;
            R0Out       <= '0;
            regWriteOut <= 1'b0;
            validOut    <= 1'b0;
            memErr      <= 1'b0;
        end else begin
            memReq      <= memreq_d;
            memWe       <= memwe_d;
            memAddr     <= memaddr_d;
            memWData    <= memwdata_d;
            lat_dest    <= lat_dest_d;
            lat_rw      <= lat_rw_d;
            lat_read    <= lat_read_d;
            rdata_cap   <= rdata_cap_d;
            aluOut      <= aluout_d;
            dataOut     <= dataout_d;
            R0Out       <= r0out_d;
            regWriteOut <= rwout_d;
            validOut    <= validout_d;
            memErr      <= memerr_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed pipeline/memory scenarios,
// retirements and error pulses checked by an independent monitor.
module tb_mem_access_stage;

    localparam int W = 37; // {aluOut, dataOut, R0Out, regWriteOut}

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        hazard = 1'b0;
    logic        validIn = 1'b0;
    logic [15:0] aluIn = '0;
    logic [15:0] storeData = '0;
    logic [3:0]  destReg = '0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic        regWrite = 1'b0;
    logic        stallOut;
    logic        memReq;
    logic        memWe;
    logic [15:0] memAddr;
    logic [15:0] memWData;
    logic        memAck = 1'b0;
    logic [15:0] memRData = '0;
    logic [15:0] aluOut;
    logic [15:0] dataOut;
    logic [3:0]  R0Out;
    logic        regWriteOut;
    logic        validOut;
    logic        memErr;
    logic [1:0]  state_dbg;

    logic [W-1:0] exp_q[$];
    int           err_exp = 0;
    int           n_checks = 0;
    int           n_err = 0;
    logic         hz_at_edge = 1'b0;

    mem_access_stage dut (
        .clk(clk), .reset(reset), .hazard(hazard), .validIn(validIn),
        .aluIn(aluIn), .storeData(storeData), .destReg(destReg),
        .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
        .stallOut(stallOut), .memReq(memReq), .memWe(memWe),
        .memAddr(memAddr), .memWData(memWData), .memAck(memAck),
        .memRData(memRData), .aluOut(aluOut), .dataOut(dataOut),
        .R0Out(R0Out), .regWriteOut(regWriteOut), .validOut(validOut),
        .memErr(memErr), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge clk) hz_at_edge <= hazard;

    always @(negedge clk) begin
        if (!reset && validOut && !hz_at_edge) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_retire: got %h with no expected entry at %0t",
                         {aluOut, dataOut, R0Out, regWriteOut}, $time);
            end else begin
                check("retire", {aluOut, dataOut, R0Out, regWriteOut}, exp_q.pop_front());
            end
        end
        if (!reset && memErr) begin
            n_checks++;
            if (err_exp > 0) begin
                err_exp--;
            end else begin
                n_err++;
                $display("FAIL unexpected_memErr: got 1 expected 0 at %0t", $time);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        validIn  = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [3:0] dest, input logic rw);
        validIn   = 1'b1;
        memRead   = rd;
        memWrite  = wr;
        aluIn     = addr;
        storeData = wdata;
        destReg   = dest;
        regWrite  = rw;
    endtask

    task automatic mem_op(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [3:0] dest, input logic rw, input int ack_cycle,
                          input logic [15:0] rdata);
        issue(!wr, wr, addr, wdata, dest, rw);
        exp_q.push_back({addr, (wr ? 16'h0000 : rdata), dest, rw});
        tick();
        drive_idle();
        for (int i = 1; i <= ack_cycle; i++) begin
            check("memReq_high", W'(memReq), W'(1));
            check("memAddr", W'(memAddr), W'(addr));
            check("memWe", W'(memWe), W'(wr));
            check("stall_busy", W'(stallOut), W'(1));
            if (wr) check("memWData", W'(memWData), W'(wdata));
            if (i == ack_cycle) begin
                memAck   = 1'b1;
                memRData = rdata;
            end
            tick();
        end
        memAck   = 1'b0;
        memRData = 16'hDEAD;
        check("memReq_dropped", W'(memReq), W'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int req_cycles;

        repeat (3) tick();
        check("rst_outputs", {aluOut, dataOut, R0Out, regWriteOut}, '0);
        check("rst_ctrl", W'({validOut, memErr, memReq, memWe, stallOut, state_dbg}), W'(0));
        check("rst_memaddr", W'({memAddr, memWData}), W'(0));
        reset = 1'b0;
        tick();

        // Non-memory ops back to back
        issue(1'b0, 1'b0, 16'h1EDF, 16'h0, 4'h3, 1'b1);
        exp_q.push_back({16'h1EDF, 16'h0000, 4'h3, 1'b1});
        tick();
        check("stall_idle", W'(stallOut), W'(0));
        issue(1'b0, 1'b0, 16'h2222, 16'h0, 4'hA, 1'b0);
        exp_q.push_back({16'h2222, 16'h0000, 4'hA, 1'b0});
        tick();

        // Hazard freeze: pending op not accepted, outputs held
        hazard = 1'b1;
        issue(1'b0, 1'b0, 16'hBEEF, 16'h0, 4'h1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("hz_hold_valid", W'(validOut), W'(1));
            check("hz_hold_alu", W'(aluOut), W'(16'h2222));
            check("hz_stall", W'(stallOut), W'(1));
        end
        hazard = 1'b0;
        exp_q.push_back({16'hBEEF, 16'h0000, 4'h1, 1'b1});
        tick();
        drive_idle();

        // Load, ack in third request cycle
        mem_op(1'b0, 16'h0040, 16'h0, 4'h5, 1'b1, 3, 16'h7EF3);
        tick();
        check("load_valid_1cyc", W'(validOut), W'(0));

        // Store, ack in first request cycle
        mem_op(1'b1, 16'h0123, 16'h7EF0, 4'h7, 1'b0, 1, 16'h5555);

        // Ack under hazard -> HOLD, retire with captured data on release
        issue(1'b1, 1'b0, 16'h0080, 16'h0, 4'h9, 1'b1);
        tick();
        drive_idle();
        memAck   = 1'b1;
        memRData = 16'h1234;
        hazard   = 1'b1;
        tick();
        memAck   = 1'b0;
        memRData = 16'hDEAD;
        for (int i = 0; i < 2; i++) begin
            check("hold_state", W'(state_dbg), W'(2));
            check("hold_memReq", W'(memReq), W'(0));
            check("hold_outputs", W'({validOut, aluOut}), W'({1'b0, 16'h0123}));
            if (i == 0) tick();
        end
        hazard = 1'b0;
        exp_q.push_back({16'h0080, 16'h1234, 4'h9, 1'b1});
        tick();
        check("hold_exit_idle", W'(state_dbg), W'(0));

        // Timeout: no ack
        issue(1'b1, 1'b0, 16'h0200, 16'h0, 4'h4, 1'b1);
        err_exp++;
        tick();
        drive_idle();
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (!memReq) break;
            req_cycles++;
            tick();
        end
        check("timeout_req_cycles", W'(req_cycles), W'(15));
        check("timeout_valid", W'(validOut), W'(0));
        check("timeout_idle", W'(state_dbg), W'(0));
        memAck   = 1'b1;
        memRData = 16'hAAAA;
        tick();
        memAck = 1'b0;
        check("late_ack_ignored", W'({validOut, memReq}), W'(0));
        issue(1'b0, 1'b0, 16'h5A5A, 16'h0, 4'h2, 1'b1);
        exp_q.push_back({16'h5A5A, 16'h0000, 4'h2, 1'b1});
        tick();
        drive_idle();

        // Reset in the middle of an access, then a late ack
        issue(1'b1, 1'b0, 16'h0300, 16'h0, 4'h6, 1'b1);
        tick();
        drive_idle();
        tick();
        reset = 1'b1;
        tick();
        check("midrst_memReq", W'(memReq), W'(0));
        check("midrst_outputs", {aluOut, dataOut, R0Out, regWriteOut}, '0);
        check("midrst_state", W'({validOut, state_dbg}), W'(0));
        reset    = 1'b0;
        memAck   = 1'b1;
        memRData = 16'hFFFF;
        tick();
        memAck = 1'b0;
        check("post_rst_ack", W'({validOut, memReq, state_dbg}), W'(0));

        // Illegal op: both read and write
        issue(1'b1, 1'b1, 16'h0400, 16'h0, 4'h8, 1'b1);
        err_exp++;
        tick();
        drive_idle();
        check("illegal_no_req", W'({memReq, validOut, state_dbg}), W'(0));

        repeat (3) tick();
        check("queue_drained", W'(exp_q.size()), W'(0));
        check("memErr_all_seen", W'(err_exp), W'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
